// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake between the multicycle control FSM and the memory port.
//   mem_re    : read request (instruction fetch or load)
//   mem_we    : write request (store)
//   adr_src   : address select, 0 = PC, 1 = alu_out
//   mem_ready : memory completes the current access this cycle
// master = control FSM, slave = memory side.
interface multicycle_ctrl_fsm_if;
  logic mem_re;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_re, mem_we, adr_src, input mem_ready);
  modport slave  (input mem_re, mem_we, adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath enable and mux select.
// Ports:
//   clk, rstn        : clock (rising edge), async active-low reset
//   mem              : memory handshake (mem_re, mem_we, adr_src, mem_ready)
//   opcode, funct3   : fields of the instruction register
//   alu_zero, alu_lsb: ALU flags for branch resolution
//   pc_we, old_pc_we, ir_we, rf_we : register write enables
//   alu_a_src, alu_b_src, alu_ctrl, result_src : datapath selects
//   illegal_instr    : set while parked in TRAP
//   instret          : one-cycle pulse per retired instruction
// Outputs are decoded combinationally from the state (plus mem_ready and the
// branch condition) and forced to 0 while rstn is low, so a reset asserted
// mid-access drops every enable without waiting for a clock.
module multicycle_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                   clk,
  input  logic                   rstn,
  multicycle_ctrl_fsm_if.master  mem,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   alu_zero,
  input  logic                   alu_lsb,
  output logic                   pc_we,
  output logic                   old_pc_we,
  output logic                   ir_we,
  output logic                   rf_we,
  output logic [1:0]             alu_a_src,
  output logic [1:0]             alu_b_src,
  output logic [1:0]             alu_ctrl,
  output logic [1:0]             result_src,
  output logic                   illegal_instr,
  output logic                   instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    JAL      = 4'd9,
    JALR     = 4'd10,
    LUI      = 4'd11,
    ALU_WB   = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state;
  logic   taken;
  logic   adr_src_c, mem_re_c, mem_we_c;

  // Branch condition; BEQ/BNE use the zero flag of rs1-rs2, the ordered
  // compares use the SLT/SLTU result bit. 010/011 are not branches.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = alu_zero;
      3'b001:         taken = !alu_zero;
      3'b100, 3'b110: taken = alu_lsb;
      3'b101, 3'b111: taken = !alu_lsb;
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= state_t'(RESET_STATE);
    end else begin
      case (state)
        FETCH:    if (mem.mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R:                state <= EXEC_R;
            OP_I:                state <= EXEC_I;
            OP_LOAD, OP_STORE:   state <= MEM_ADDR;
            OP_BRANCH:           state <= BRANCH;
            OP_JAL:              state <= JAL;
            OP_JALR:             state <= JALR;
            OP_LUI:              state <= LUI;
            OP_AUIPC:            state <= ALU_WB;
            OP_FENCE, OP_SYSTEM: state <= FETCH;
            default:             state <= TRAP;
          endcase
        end
        EXEC_R, EXEC_I, LUI, JAL: state <= ALU_WB;
        MEM_ADDR: state <= (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem.mem_ready) state <= MEM_WB;
        MEM_WR:   if (mem.mem_ready) state <= FETCH;
        JALR:     state <= JAL;
        MEM_WB, BRANCH, ALU_WB: state <= FETCH;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_we         = 1'b0;
    old_pc_we     = 1'b0;
    ir_we         = 1'b0;
    rf_we         = 1'b0;
    adr_src_c     = 1'b0;
    mem_re_c      = 1'b0;
    mem_we_c      = 1'b0;
    alu_a_src     = 2'b00;
    alu_b_src     = 2'b00;
    alu_ctrl      = 2'b00;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    instret       = 1'b0;
    if (rstn) begin
      case (state)
        FETCH: begin
          // PC+4 goes straight onto the result bus so PC updates with the IR.
          mem_re_c   = 1'b1;
          alu_b_src  = 2'b10;
          result_src = 2'b10;
          ir_we      = mem.mem_ready;
          pc_we      = mem.mem_ready;
          old_pc_we  = mem.mem_ready;
        end
        DECODE: begin
          // old_pc+imm into alu_out: branch/JAL target and AUIPC result.
          alu_a_src = 2'b01;
          alu_b_src = 2'b01;
          instret   = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);
        end
        EXEC_R: begin
          alu_a_src = 2'b10;
          alu_ctrl  = 2'b10;
        end
        EXEC_I: begin
          alu_a_src = 2'b10;
          alu_b_src = 2'b01;
          alu_ctrl  = 2'b10;
        end
        MEM_ADDR, JALR: begin
          alu_a_src = 2'b10;
          alu_b_src = 2'b01;
        end
        MEM_RD: begin
          adr_src_c = 1'b1;
          mem_re_c  = 1'b1;
        end
        MEM_WB: begin
          result_src = 2'b01;
          rf_we      = 1'b1;
          instret    = 1'b1;
        end
        MEM_WR: begin
          adr_src_c = 1'b1;
          mem_we_c  = 1'b1;
          instret   = mem.mem_ready;
        end
        BRANCH: begin
          alu_a_src = 2'b10;
          alu_ctrl  = 2'b01;
          pc_we     = taken;
          instret   = 1'b1;
        end
        JAL: begin
          // Jump from alu_out while the ALU forms the link address old_pc+4.
          pc_we     = 1'b1;
          alu_a_src = 2'b01;
          alu_b_src = 2'b10;
        end
        LUI: begin
          alu_a_src = 2'b11;
          alu_b_src = 2'b01;
        end
        ALU_WB: begin
          rf_we   = 1'b1;
          instret = 1'b1;
        end
        TRAP:    illegal_instr = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.adr_src = adr_src_c;
  assign mem.mem_re  = mem_re_c;
  assign mem.mem_we  = mem_we_c;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero, alu_lsb;
  logic       pc_we, old_pc_we, ir_we, rf_we;
  logic [1:0] alu_a_src, alu_b_src, alu_ctrl, result_src;
  logic       illegal_instr, instret;

  multicycle_ctrl_fsm_if mif();

  multicycle_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rstn(rstn), .mem(mif),
    .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
    .pc_we(pc_we), .old_pc_we(old_pc_we), .ir_we(ir_we), .rf_we(rf_we),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .illegal_instr(illegal_instr), .instret(instret)
  );

  always #5 clk = ~clk;

  // {pc_we, old_pc_we, ir_we, adr_src, mem_re, mem_we, rf_we,
  //  alu_a_src, alu_b_src, alu_ctrl, result_src, illegal_instr, instret}
  logic [16:0] obs;
  assign obs = {pc_we, old_pc_we, ir_we, mif.adr_src, mif.mem_re, mif.mem_we, rf_we,
                alu_a_src, alu_b_src, alu_ctrl, result_src, illegal_instr, instret};

  function automatic logic [16:0] ex(
    input logic pc, old, ir, adr, re, we, rf,
    input logic [1:0] a, b, ctl, res,
    input logic ill, ret);
    return {pc, old, ir, adr, re, we, rf, a, b, ctl, res, ill, ret};
  endfunction

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        z;
    logic        lsb;
    logic        rdy;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  logic [16:0] F_RDY, F_WAIT, DEC, DEC_NOP, EXR, EXI, LUI_E, MA, MRD, MWB,
               MWR_W, MWR_R, BR_T, BR_N, JALR_E, JAL_E, AWB, TRAPE, ZERO;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
    ST = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111,
    LU = 7'b0110111, AU = 7'b0010111, FN = 7'b0001111, SY = 7'b1110011,
    BAD = 7'b1111111;

  task automatic chk(input string nm, input logic [16:0] e);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", nm, obs, e);
    end
  endtask

  task automatic step(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                      input logic lsb, input logic rdy, input logic [16:0] e,
                      input string nm);
    opcode = opc; funct3 = f3; alu_zero = z; alu_lsb = lsb; mif.mem_ready = rdy;
    @(negedge clk);
    chk(nm, e);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [6:0] opc, input logic [2:0] f3,
                              input logic z, input logic lsb, input logic rdy,
                              input logic [16:0] e, input string nm);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.z = z; v.lsb = lsb; v.rdy = rdy; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    F_RDY   = ex(1,1,1,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
    F_WAIT  = ex(0,0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
    DEC     = ex(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
    DEC_NOP = ex(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,1);
    EXR     = ex(0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0);
    EXI     = ex(0,0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0,0);
    LUI_E   = ex(0,0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 0,0);
    MA      = ex(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
    MRD     = ex(0,0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
    MWB     = ex(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0,1);
    MWR_W   = ex(0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
    MWR_R   = ex(0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,1);
    BR_T    = ex(1,0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 0,1);
    BR_N    = ex(0,0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 0,1);
    JALR_E  = ex(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
    JAL_E   = ex(1,0,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0);
    AWB     = ex(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,1);
    TRAPE   = ex(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0);
    ZERO    = '0;

    // Back-to-back instructions from reset, one row per clock.
    add(R, 0,0,0,1, F_RDY, "add_fetch");   add(R, 0,0,0,1, DEC, "add_dec");
    add(R, 0,0,0,1, EXR, "add_exec");      add(R, 0,0,0,1, AWB, "add_wb");
    add(I, 0,0,0,1, F_RDY, "addi_fetch");  add(I, 0,0,0,1, DEC, "addi_dec");
    add(I, 0,0,0,1, EXI, "addi_exec");     add(I, 0,0,0,1, AWB, "addi_wb");
    add(LU,0,0,0,1, F_RDY, "lui_fetch");   add(LU,0,0,0,1, DEC, "lui_dec");
    add(LU,0,0,0,1, LUI_E, "lui_exec");    add(LU,0,0,0,1, AWB, "lui_wb");
    add(AU,0,0,0,1, F_RDY, "auipc_fetch"); add(AU,0,0,0,1, DEC, "auipc_dec");
    add(AU,0,0,0,1, AWB, "auipc_wb");
    add(FN,0,0,0,1, F_RDY, "fence_fetch"); add(FN,0,0,0,1, DEC_NOP, "fence_dec");
    add(SY,0,0,0,1, F_RDY, "sys_fetch");   add(SY,0,0,0,1, DEC_NOP, "sys_dec");
    add(ST,0,0,0,0, F_WAIT, "sw_fetch_wait"); add(ST,0,0,0,1, F_RDY, "sw_fetch");
    add(ST,0,0,0,1, DEC, "sw_dec");        add(ST,0,0,0,1, MA, "sw_addr");
    add(ST,0,0,0,0, MWR_W, "sw_wr_wait");  add(ST,0,0,0,1, MWR_R, "sw_wr_done");
    add(BR,0,1,0,1, F_RDY, "beq_fetch");   add(BR,0,1,0,1, DEC, "beq_dec");
    add(BR,0,1,0,1, BR_T, "beq_taken");
    add(BR,3'b100,1,0,1, F_RDY, "blt_fetch"); add(BR,3'b100,1,0,1, DEC, "blt_dec");
    add(BR,3'b100,1,0,1, BR_N, "blt_not");
    add(BR,3'b111,0,0,1, F_RDY, "bgeu_fetch"); add(BR,3'b111,0,0,1, DEC, "bgeu_dec");
    add(BR,3'b111,0,0,1, BR_T, "bgeu_taken");
    add(BR,3'b010,1,1,1, F_RDY, "b010_fetch"); add(BR,3'b010,1,1,1, DEC, "b010_dec");
    add(BR,3'b010,1,1,1, BR_N, "b010_never");
    add(JL,0,0,0,1, F_RDY, "jal_fetch");   add(JL,0,0,0,1, DEC, "jal_dec");
    add(JL,0,0,0,1, JAL_E, "jal_jump");    add(JL,0,0,0,1, AWB, "jal_wb");

    rstn = 1'b0; opcode = R; funct3 = 0; alu_zero = 0; alu_lsb = 0; mif.mem_ready = 1'b1;
    #2;
    chk("reset_outputs", ZERO);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    foreach (tbl[k]) step(tbl[k].opc, tbl[k].f3, tbl[k].z, tbl[k].lsb, tbl[k].rdy,
                          tbl[k].exp, tbl[k].name);

    // Load with two memory wait states in MEM_RD: 7 cycles total.
    step(LD,0,0,0,1, F_RDY, "lw_fetch");
    step(LD,0,0,0,1, DEC, "lw_dec");
    step(LD,0,0,0,1, MA, "lw_addr");
    step(LD,0,0,0,0, MRD, "lw_rd_wait1");
    step(LD,0,0,0,0, MRD, "lw_rd_wait2");
    step(LD,0,0,0,1, MRD, "lw_rd_done");
    step(LD,0,0,0,1, MWB, "lw_wb");

    // BNE, both outcomes.
    step(BR,3'b001,0,0,1, F_RDY, "bne_fetch");
    step(BR,3'b001,0,0,1, DEC, "bne_dec");
    step(BR,3'b001,0,0,1, BR_T, "bne_taken");
    step(BR,3'b001,1,0,1, F_RDY, "bne2_fetch");
    step(BR,3'b001,1,0,1, DEC, "bne2_dec");
    step(BR,3'b001,1,0,1, BR_N, "bne_not");

    // JALR -> JAL -> ALU_WB.
    step(JR,0,0,0,1, F_RDY, "jalr_fetch");
    step(JR,0,0,0,1, DEC, "jalr_dec");
    step(JR,0,0,0,1, JALR_E, "jalr_target");
    step(JR,0,0,0,1, JAL_E, "jalr_jump");
    step(JR,0,0,0,1, AWB, "jalr_wb");

    // Illegal opcode parks in TRAP until reset.
    step(BAD,0,0,0,1, F_RDY, "bad_fetch");
    step(BAD,0,0,0,1, DEC, "bad_dec");
    for (int c = 0; c < 20; c++)
      step(BAD,3'(c),c[0],c[1],c[2], TRAPE, "trap_hold");
    rstn = 1'b0;
    #1 chk("trap_reset", ZERO);
    @(posedge clk); #1 rstn = 1'b1;
    step(R,0,0,0,1, F_RDY, "trap_refetch");

    // Reset dropped during a stalled store.
    step(ST,0,0,0,1, DEC, "rst_sw_dec");
    step(ST,0,0,0,1, MA, "rst_sw_addr");
    opcode = ST; mif.mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_sw_wr", MWR_W);
    #2 rstn = 1'b0;
    #1 chk("rst_async_clear", ZERO);
    @(posedge clk); #1 rstn = 1'b1;
    step(R,0,0,0,0, F_WAIT, "rst_after_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
